// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse tracker: packet framing states and
// the bit positions of the status byte (byte0) of a standard 3-byte packet.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT0  = 2'd1,
    GOT1  = 2'd2,
    APPLY = 2'd3
  } state_t;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// Byte stream in from the PS/2 receiver and cursor/button state out to the
// consumer. The tracker takes the slave side.
interface ps2_mouse_tracker_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic          left_btn;
  logic          right_btn;
  logic          middle_btn;
  logic          left_click;
  logic          right_click;
  logic          move_valid;
  logic          sync_err;

  modport master (
    output byte_valid, byte_data,
    input  x_pos, y_pos, left_btn, right_btn, middle_btn,
    input  left_click, right_click, move_valid, sync_err
  );

  modport slave (
    input  byte_valid, byte_data,
    output x_pos, y_pos, left_btn, right_btn, middle_btn,
    output left_click, right_click, move_valid, sync_err
  );
endinterface

// File: rtl/ps2_axis_accum.sv
// One cursor axis: masks and scales a 9-bit packet delta, adds it to the
// position in a widened signed sum and clamps to 0..MAX (never wraps).
module ps2_axis_accum #(
  parameter int W         = 10,
  parameter int MAX       = 639,
  parameter int INIT      = 320,
  parameter int DIV_SHIFT = 0,
  parameter bit NEG       = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         apply,
  input  logic         sign,
  input  logic         ovf,
  input  logic [7:0]   mag,
  output logic [W-1:0] pos
);
  localparam int SW = ((W > 9) ? W : 9) + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);
  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic signed [8:0]    delta;
  logic signed [8:0]    scaled;
  logic signed [SW-1:0] step;
  logic signed [SW-1:0] base;
  logic signed [SW-1:0] sum;
  logic [W-1:0]         pos_reg;
  logic [W-1:0]         pos_next;

  always_comb begin
    delta  = ovf ? 9'sd0 : $signed({sign, mag});
    // Arithmetic shift rounds toward -inf, so a -1 step survives any shift.
    scaled = delta >>> DIV_SHIFT;
    step   = {{(SW-9){scaled[8]}}, scaled};
    base   = $signed({{(SW-W){1'b0}}, pos_reg});
    sum    = NEG ? (base - step) : (base + step);
    if (sum[SW-1])
      pos_next = '0;
    else if (sum > MAX_S)
      pos_next = MAX_V;
    else
      pos_next = sum[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pos_reg <= INIT_V;
    else if (apply)
      pos_reg <= pos_next;
  end

  assign pos = pos_reg;
endmodule

// File: rtl/ps2_mouse_tracker.sv
// Frames PS/2 bytes into 3-byte mouse packets (sync check, inter-byte timeout)
// and drives a clamped cursor position, button levels and click pulses.
module ps2_mouse_tracker
  import ps2_mouse_pkg::*;
#(
  parameter int XW          = 10,
  parameter int YW          = 10,
  parameter int MAX_X       = 639,
  parameter int MAX_Y       = 479,
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240,
  parameter int DIV_SHIFT   = 0,
  parameter int Y_INVERT    = 1,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ps2_mouse_tracker_if.slave    bus
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state_reg, state_next;
  logic [7:0]    b0_reg, b0_next;
  logic [7:0]    b1_reg, b1_next;
  logic [7:0]    b2_reg, b2_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          sync_err_reg, sync_err_next;
  logic          move_valid_reg;
  logic [2:0]    btn_reg;
  logic [1:0]    click_reg;
  logic          apply;
  logic [XW-1:0] x_pos_w;
  logic [YW-1:0] y_pos_w;

  always_comb begin
    state_next    = state_reg;
    b0_next       = b0_reg;
    b1_next       = b1_reg;
    b2_next       = b2_reg;
    timer_next    = timer_reg;
    sync_err_next = 1'b0;
    apply         = 1'b0;
    case (state_reg)
      // APPLY also listens for byte0 so back-to-back packets are never lost.
      IDLE, APPLY: begin
        apply      = (state_reg == APPLY) && b0_reg[SYNC];
        timer_next = '0;
        state_next = IDLE;
        if (bus.byte_valid) begin
          if (bus.byte_data[SYNC]) begin
            b0_next    = bus.byte_data;
            state_next = GOT0;
          end else begin
            sync_err_next = 1'b1;
          end
        end
      end
      GOT0, GOT1: begin
        if (bus.byte_valid) begin
          timer_next = '0;
          if (state_reg == GOT0) begin
            b1_next    = bus.byte_data;
            state_next = GOT1;
          end else begin
            b2_next    = bus.byte_data;
            state_next = APPLY;
          end
        end else if (timer_reg == TIMER_LAST) begin
          timer_next    = '0;
          state_next    = IDLE;
          sync_err_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      b0_reg         <= '0;
      b1_reg         <= '0;
      b2_reg         <= '0;
      timer_reg      <= '0;
      sync_err_reg   <= 1'b0;
      move_valid_reg <= 1'b0;
      btn_reg        <= '0;
      click_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      b0_reg         <= b0_next;
      b1_reg         <= b1_next;
      b2_reg         <= b2_next;
      timer_reg      <= timer_next;
      sync_err_reg   <= sync_err_next;
      move_valid_reg <= apply;
      if (apply) begin
        btn_reg   <= {b0_reg[BTN_M], b0_reg[BTN_R], b0_reg[BTN_L]};
        click_reg <= {b0_reg[BTN_R], b0_reg[BTN_L]} & ~btn_reg[1:0];
      end else begin
        click_reg <= '0;
      end
    end
  end

  ps2_axis_accum #(
    .W(XW), .MAX(MAX_X), .INIT(INIT_X), .DIV_SHIFT(DIV_SHIFT), .NEG(1'b0)
  ) u_x_axis (
    .clk(clk), .reset_n(reset_n), .apply(apply),
    .sign(b0_reg[XSIGN]), .ovf(b0_reg[XOVF]), .mag(b1_reg), .pos(x_pos_w)
  );

  ps2_axis_accum #(
    .W(YW), .MAX(MAX_Y), .INIT(INIT_Y), .DIV_SHIFT(DIV_SHIFT), .NEG(Y_INVERT != 0)
  ) u_y_axis (
    .clk(clk), .reset_n(reset_n), .apply(apply),
    .sign(b0_reg[YSIGN]), .ovf(b0_reg[YOVF]), .mag(b2_reg), .pos(y_pos_w)
  );

  assign bus.x_pos       = x_pos_w;
  assign bus.y_pos       = y_pos_w;
  assign bus.left_btn    = btn_reg[0];
  assign bus.right_btn   = btn_reg[1];
  assign bus.middle_btn  = btn_reg[2];
  assign bus.left_click  = click_reg[0];
  assign bus.right_click = click_reg[1];
  assign bus.move_valid  = move_valid_reg;
  assign bus.sync_err    = sync_err_reg;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench: two trackers (DIV_SHIFT 0 and 2) share one byte stream;
// a reference model queues expected events, a negedge monitor compares them.
module tb_ps2_mouse_tracker;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_mouse_tracker_if #(.XW(10), .YW(10)) bus0 ();
  ps2_mouse_tracker_if #(.XW(10), .YW(10)) bus1 ();

  ps2_mouse_tracker #(
    .XW(10), .YW(10), .MAX_X(639), .MAX_Y(479), .INIT_X(320), .INIT_Y(240),
    .DIV_SHIFT(0), .Y_INVERT(1), .TIMEOUT_CYC(TO)
  ) dut0 (.clk(clk), .reset_n(rst_n), .bus(bus0));

  ps2_mouse_tracker #(
    .XW(10), .YW(10), .MAX_X(639), .MAX_Y(479), .INIT_X(320), .INIT_Y(240),
    .DIV_SHIFT(2), .Y_INVERT(1), .TIMEOUT_CYC(TO)
  ) dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1));

  typedef struct {
    bit         is_move;
    int         due;
    int         x;
    int         y;
    logic [2:0] btn;
    logic [1:0] clicks;
  } ev_t;

  ev_t        q0[$];
  ev_t        q1[$];
  int         mx[2];
  int         my[2];
  logic [2:0] mb[2];

  // ---------------- reference model ----------------
  function automatic int floor_div_pow2(int d, int s);
    int p = 1 << s;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic push_ev(input int inst, input ev_t e);
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  function automatic ev_t pop_ev(input int inst);
    if (inst == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int qsize(input int inst);
    return (inst == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 320;
      my[i] = 240;
      mb[i] = 3'b000;
    end
  endtask

  task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int due);
    for (int i = 0; i < 2; i++) begin
      int  dx;
      int  dy;
      int  sh;
      ev_t e;
      sh = (i == 0) ? 0 : 2;
      dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
      dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
      mx[i] = clampi(mx[i] + floor_div_pow2(dx, sh), 639);
      my[i] = clampi(my[i] - floor_div_pow2(dy, sh), 479);
      e.is_move = 1'b1;
      e.due     = due;
      e.x       = mx[i];
      e.y       = my[i];
      e.btn     = b0[2:0];
      e.clicks  = b0[1:0] & ~mb[i][1:0];
      mb[i]     = b0[2:0];
      push_ev(i, e);
    end
  endtask

  task automatic model_sync(input int due);
    for (int i = 0; i < 2; i++) begin
      ev_t e;
      e.is_move = 1'b0;
      e.due     = due;
      e.x       = 0;
      e.y       = 0;
      e.btn     = 3'b000;
      e.clicks  = 2'b00;
      push_ev(i, e);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got %0d, required %0d", name, inst, cyc, act, exp);
    end
  endtask

  task automatic mon(input int inst, input logic mv, input logic se,
                     input logic [9:0] x, input logic [9:0] y,
                     input logic [2:0] btn, input logic [1:0] ck);
    ev_t e;
    if (ck != 2'b00) chk("click_needs_move_valid", inst, int'(mv), 1);
    if (mv) begin
      if (qsize(inst) == 0) begin
        chk("unexpected_move_valid", inst, 1, 0);
      end else begin
        e = pop_ev(inst);
        chk("event_is_move", inst, 1, int'(e.is_move));
        if (e.due >= 0) chk("move_latency_cycle", inst, cyc, e.due);
        chk("x_pos", inst, int'(x), e.x);
        chk("y_pos", inst, int'(y), e.y);
        chk("buttons_mrl", inst, int'(btn), int'(e.btn));
        chk("clicks_rl", inst, int'(ck), int'(e.clicks));
      end
    end
    if (se) begin
      if (qsize(inst) == 0) begin
        chk("unexpected_sync_err", inst, 1, 0);
      end else begin
        e = pop_ev(inst);
        chk("event_is_sync_err", inst, 0, int'(e.is_move));
        if (e.due >= 0) chk("sync_err_cycle", inst, cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus0.move_valid, bus0.sync_err, bus0.x_pos, bus0.y_pos,
          {bus0.middle_btn, bus0.right_btn, bus0.left_btn},
          {bus0.right_click, bus0.left_click});
      mon(1, bus1.move_valid, bus1.sync_err, bus1.x_pos, bus1.y_pos,
          {bus1.middle_btn, bus1.right_btn, bus1.left_btn},
          {bus1.right_click, bus1.left_click});
    end
  end

  task automatic check_rest_state(input string name);
    chk({name, "_x"}, 0, int'(bus0.x_pos), mx[0]);
    chk({name, "_y"}, 0, int'(bus0.y_pos), my[0]);
    chk({name, "_x"}, 1, int'(bus1.x_pos), mx[1]);
    chk({name, "_y"}, 1, int'(bus1.y_pos), my[1]);
    chk({name, "_btn"}, 0, int'({bus0.middle_btn, bus0.right_btn, bus0.left_btn}), 0);
    chk({name, "_btn"}, 1, int'({bus1.middle_btn, bus1.right_btn, bus1.left_btn}), 0);
    chk({name, "_strobes"}, 0,
        int'({bus0.move_valid, bus0.sync_err, bus0.left_click, bus0.right_click}), 0);
    chk({name, "_strobes"}, 1,
        int'({bus1.move_valid, bus1.sync_err, bus1.left_click, bus1.right_click}), 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (q0.size() + q1.size()) > 0; k++) @(negedge clk);
    if ((q0.size() + q1.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", q0.size() + q1.size());
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [7:0] d);
    bus0.byte_valid = v;
    bus0.byte_data  = d;
    bus1.byte_valid = v;
    bus1.byte_data  = d;
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive(1'b1, d);
    @(negedge clk);
    drive(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int gmin, input int gmax);
    send_byte(b0);
    idle(int'($urandom_range(gmin, gmax)));
    send_byte(b1);
    idle(int'($urandom_range(gmin, gmax)));
    model_packet(b0, b1, b2, cyc + 2);
    send_byte(b2);
    $display("packet %02h %02h %02h -> inst0 x=%0d y=%0d, inst1 x=%0d y=%0d",
             b0, b1, b2, mx[0], my[0], mx[1], my[1]);
  endtask

  task automatic send_bad(input logic [7:0] d);
    model_sync(cyc + 1);
    send_byte(d);
    $display("bad first byte %02h -> sync_err expected", d);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, bad;
    drive(1'b0, 8'h00);
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_rest_state("reset");
    rst_n = 1'b1;
    idle(1);

    send_packet(8'h08, 8'h05, 8'h03, 0, 2);
    send_packet(8'h18, 8'hFB, 8'h00, 0, 1);
    send_packet(8'h18, 8'h00, 8'h00, 0, 0);
    send_packet(8'h18, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) send_packet(8'h08, 8'h7F, 8'h00, 0, 1);
    send_packet(8'h08, 8'h5C, 8'h00, 0, 1);
    for (int i = 0; i < 6; i++) send_packet(8'h08, 8'h7F, 8'h00, 0, 1);

    send_bad(8'h00);
    send_packet(8'h09, 8'h00, 8'h00, 0, 1);
    send_packet(8'h09, 8'h00, 8'h00, 0, 1);
    send_packet(8'h0A, 8'h00, 8'h00, 0, 1);

    idle(2);
    model_sync(-1);
    send_byte(8'h08);
    idle(1);
    send_byte(8'h10);
    $display("partial packet 08 10 -> timeout sync_err expected");
    idle(TO + 4);
    send_packet(8'h08, 8'h03, 8'h01, 0, 1);
    send_packet(8'h08, 8'h04, 8'h02, TO - 3, TO - 3);

    send_packet(8'h48, 8'hFF, 8'h02, 0, 1);
    send_packet(8'h18, 8'hFF, 8'h00, 0, 1);
    send_packet(8'h28, 8'h00, 8'hFF, 0, 1);

    idle(3);
    drain();
    send_byte(8'h08);
    send_byte(8'h20);
    #2 rst_n = 1'b0;
    model_reset();
    #2 check_rest_state("async_midpacket_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_packet(8'h08, 8'h01, 8'h01, 0, 1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        bad = 8'($urandom);
        bad[3] = 1'b0;
        send_bad(bad);
      end
      r0 = 8'($urandom);
      r0[3] = 1'b1;
      r0[6] = ($urandom_range(0, 7) == 0);
      r0[7] = ($urandom_range(0, 7) == 0);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      send_packet(r0, r1, r2, 0, 3);
    end

    idle(3);
    drain();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
